sccomp_dbg_monitor: RTL and testbench

- Synthesizable run/halt monitor for the single-cycle MIPS sccomp; it replaces bench-only halt detection.
- Counts CPU cycles and triggers on a programmable halt PC or on a cycle-limit timeout.
- On trigger it freezes the CPU and scans the register file through the sccomp reg_sel/reg_data debug port.
- Streams a snapshot record (PC, instr, cycle count, all registers) over a valid/ready interface to a UART or trace sink.

---
 rtl/sccomp_dbg_pkg.sv | 20 ++
 rtl/sccomp_dbg_outreg.sv | 43 ++++
 rtl/sccomp_dbg_monitor.sv | 152 +++++++++++++++
 tb/tb_sccomp_dbg_monitor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sccomp_dbg_pkg.sv
// Shared constants for the sccomp debug monitor: FSM encodings, record header
// layout and trigger-reason codes.
package sccomp_dbg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDump = 2'd2;
  localparam state_t StDone = 2'd3;

  localparam int unsigned HDR_PC    = 0;
  localparam int unsigned HDR_INSTR = 1;
  localparam int unsigned HDR_CYC   = 2;
  localparam int unsigned HDR_WORDS = 3;

  localparam logic REASON_HALT    = 1'b0;
  localparam logic REASON_TIMEOUT = 1'b1;

endpackage

// File: rtl/sccomp_dbg_outreg.sv
// Single-entry valid/ready output register carrying a data word plus a last flag.
module sccomp_dbg_outreg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             can_load_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic             last_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;
  logic             last_q;

  // Accepts a new word while empty or while the current one is being taken.
  assign can_load_o = !valid_q || ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/sccomp_dbg_monitor.sv
// Run/halt monitor for sccomp: triggers on halt PC or cycle limit, freezes the CPU
// and streams a PC/instr/cycle/register snapshot over valid/ready.
module sccomp_dbg_monitor
  import sccomp_dbg_pkg::*;
#(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 1000,
  parameter int unsigned ZERO_R0    = 1,
  localparam int unsigned SEL_W     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [PC_W-1:0]  halt_pc,
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  instr,
  output logic             cpu_hold,
  output logic [SEL_W-1:0] reg_sel,
  input  logic [PC_W-1:0]  reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [PC_W-1:0]  dump_data,
  output logic             dump_last,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned NWORDS = NREGS + HDR_WORDS;
  localparam int unsigned IDX_W  = $clog2(NWORDS + 1);

  state_t           state_q;
  logic [CNT_W-1:0] cycle_count_q, cnt_inc;
  logic [PC_W-1:0]  hdr_pc_q, hdr_instr_q;
  logic [CNT_W-1:0] hdr_cyc_q;
  logic             timeout_q, done_q, primed_q;
  logic [IDX_W-1:0] idx_q, idx_nx;
  logic [SEL_W-1:0] reg_sel_q;
  logic             halt_hit, to_hit, trig;
  logic             can_load, load, last_fire;
  logic [PC_W-1:0]  word;
  logic             word_last;

  always_comb begin
    halt_hit  = (pc == halt_pc);
    to_hit    = (cycle_count_q == CNT_W'(MAX_CYCLES - 1));
    trig      = (state_q == StRun) && arm && (halt_hit || to_hit);
    cnt_inc   = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CNT_W'(1);
    idx_nx    = idx_q + IDX_W'(1);
    // primed_q gives reg_sel/reg_data one cycle to settle before the first load.
    load      = (state_q == StDump) && primed_q && (idx_q < IDX_W'(NWORDS)) && can_load;
    last_fire = dump_valid && dump_ready && dump_last;
    cpu_hold  = trig || (state_q == StDump) || (state_q == StDone);
  end

  always_comb begin
    word = reg_data;
    if (idx_q == IDX_W'(HDR_PC)) begin
      word = hdr_pc_q;
    end else if (idx_q == IDX_W'(HDR_INSTR)) begin
      word = hdr_instr_q;
    end else if (idx_q == IDX_W'(HDR_CYC)) begin
      word = PC_W'(hdr_cyc_q);
    end else if ((ZERO_R0 != 0) && (idx_q == IDX_W'(HDR_WORDS))) begin
      word = '0;
    end
    word_last = (idx_q == IDX_W'(NWORDS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cycle_count_q <= '0;
      hdr_pc_q      <= '0;
      hdr_instr_q   <= '0;
      hdr_cyc_q     <= '0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      primed_q      <= 1'b0;
      idx_q         <= '0;
      reg_sel_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arm) begin
            state_q       <= StRun;
            cycle_count_q <= '0;
          end
        end
        StRun: begin
          if (!arm) begin
            state_q <= StIdle;
          end else begin
            cycle_count_q <= cnt_inc;
            if (trig) begin
              state_q     <= StDump;
              hdr_pc_q    <= pc;
              hdr_instr_q <= instr;
              hdr_cyc_q   <= cnt_inc;
              timeout_q   <= halt_hit ? REASON_HALT : REASON_TIMEOUT;
              primed_q    <= 1'b0;
              idx_q       <= '0;
              reg_sel_q   <= '0;
            end
          end
        end
        StDump: begin
          primed_q <= 1'b1;
          if (load) begin
            idx_q     <= idx_nx;
            reg_sel_q <= (idx_nx >= IDX_W'(HDR_WORDS)) ?
                         SEL_W'(idx_nx - IDX_W'(HDR_WORDS)) : '0;
          end
          if (last_fire) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        default: begin
          if (!arm) begin
            state_q   <= StIdle;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
      endcase
    end
  end

  sccomp_dbg_outreg #(
    .Width (PC_W)
  ) u_outreg (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .data_i     (word),
    .last_i     (word_last),
    .ready_i    (dump_ready),
    .can_load_o (can_load),
    .valid_o    (dump_valid),
    .data_o     (dump_data),
    .last_o     (dump_last)
  );

  assign reg_sel     = reg_sel_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_sccomp_dbg_monitor.sv
// Bench for sccomp_dbg_monitor: table of run scenarios with a scoreboard of
// expected dump words, plus hand-written reset and disarm sequences.
module tb_sccomp_dbg_monitor;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned NREGS      = 32;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned MAX_CYCLES = 1000;
  localparam int unsigned SEL_W      = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             arm = 1'b0;
  logic [PC_W-1:0]  halt_pc = '0;
  logic [PC_W-1:0]  pc = '0;
  logic [PC_W-1:0]  instr = '0;
  logic             cpu_hold;
  logic [SEL_W-1:0] reg_sel;
  logic [PC_W-1:0]  reg_data;
  logic             dump_valid;
  logic             dump_ready = 1'b0;
  logic [PC_W-1:0]  dump_data;
  logic             dump_last;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  logic [PC_W-1:0] rf [NREGS];
  assign reg_data = rf[reg_sel];

  always #5 clk = ~clk;

  sccomp_dbg_monitor #(
    .PC_W       (PC_W),
    .NREGS      (NREGS),
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES),
    .ZERO_R0    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .halt_pc     (halt_pc),
    .pc          (pc),
    .instr       (instr),
    .cpu_hold    (cpu_hold),
    .reg_sel     (reg_sel),
    .reg_data    (reg_data),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_data   (dump_data),
    .dump_last   (dump_last),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  typedef struct {
    logic [31:0] hpc;
    int          ready_mode;   // 0: always ready, 1: ready 1,0,0 repeating
    bit          disarm_dump;
    int          abort_at;     // reset after this many words, 0 = never
    logic        exp_to;
    int unsigned exp_cyc;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  vec_t  vecs [7];
  word_t sb [$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int v);
    vec_t        t;
    int          c;
    logic [31:0] p;
    bit          trig;
    int          words;
    logic [31:0] held_d;
    logic        held_l;
    bit          stalled;
    bit          rdy;
    int          incs;
    logic [SEL_W-1:0] prev_sel;
    word_t       w;
    t = vecs[v];
    for (int k = 0; k < NREGS; k++) rf[k] = k * 32'h11 + v * 32'h1000;
    arm = 1'b0;
    dump_ready = 1'b0;
    halt_pc = t.hpc;
    pc = '0;
    step();
    arm = 1'b1;
    step();
    chk($sformatf("v%0d_count_cleared", v), cycle_count, 0);
    c = 0;
    p = '0;
    trig = 1'b0;
    while (!trig && c < MAX_CYCLES) begin
      pc = p;
      instr = p ^ 32'hDEAD_0000;
      #1;
      trig = (p == t.hpc) || (c == MAX_CYCLES - 1);
      chk($sformatf("v%0d_hold_c%0d", v, c), cpu_hold, trig);
      if (trig) begin
        sb.push_back('{p, 1'b0});
        sb.push_back('{p ^ 32'hDEAD_0000, 1'b0});
        sb.push_back('{t.exp_cyc, 1'b0});
        for (int k = 0; k < NREGS; k++)
          sb.push_back('{(k == 0) ? 32'h0 : rf[k], k == NREGS - 1});
      end else begin
        p += 4;
        c++;
      end
      step();
    end
    chk($sformatf("v%0d_timeout", v), timeout, t.exp_to);
    chk($sformatf("v%0d_cycle_count", v), cycle_count, t.exp_cyc);
    chk($sformatf("v%0d_first_latency", v), dump_valid, 0);
    words = 0;
    stalled = 1'b0;
    incs = 0;
    prev_sel = reg_sel;
    held_d = '0;
    held_l = 1'b0;
    for (int i = 0; i < 300 && sb.size() > 0; i++) begin
      rdy = (t.ready_mode == 0) ? 1'b1 : (i % 3 == 0);
      dump_ready = rdy;
      if (t.disarm_dump && words >= 5) arm = 1'b0;
      #1;
      chk($sformatf("v%0d_hold_dump", v), cpu_hold, 1);
      if (int'(reg_sel) == int'(prev_sel) + 1) incs++;
      prev_sel = reg_sel;
      if (stalled) begin
        chk($sformatf("v%0d_stall_data", v), dump_data, held_d);
        chk($sformatf("v%0d_stall_last", v), dump_last, held_l);
      end
      stalled = dump_valid && !rdy;
      held_d = dump_data;
      held_l = dump_last;
      if (dump_valid && rdy) begin
        w = sb.pop_front();
        chk($sformatf("v%0d_word%0d_data", v, words), dump_data, w.data);
        chk($sformatf("v%0d_word%0d_last", v, words), dump_last, w.last);
        words++;
        if (t.abort_at != 0 && words == t.abort_at) begin
          rst = 1'b1;
          arm = 1'b0;
          #1;
          chk($sformatf("v%0d_rst_valid", v), dump_valid, 0);
          chk($sformatf("v%0d_rst_hold", v), cpu_hold, 0);
          chk($sformatf("v%0d_rst_done", v), done, 0);
          step();
          rst = 1'b0;
          dump_ready = 1'b0;
          sb.delete();
          step();
          return;
        end
      end
      step();
    end
    chk($sformatf("v%0d_words_left", v), sb.size(), 0);
    sb.delete();
    chk($sformatf("v%0d_done", v), done, 1);
    chk($sformatf("v%0d_valid_after", v), dump_valid, 0);
    chk($sformatf("v%0d_hold_done", v), cpu_hold, 1);
    chk($sformatf("v%0d_sel_steps", v), incs, NREGS - 1);
    arm = 1'b0;
    dump_ready = 1'b0;
    step();
    chk($sformatf("v%0d_done_clr", v), done, 0);
    chk($sformatf("v%0d_hold_clr", v), cpu_hold, 0);
    chk($sformatf("v%0d_timeout_clr", v), timeout, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0080, 0, 1'b0, 0, 1'b0, 33};
    vecs[1] = '{32'hFFFF_FFF0, 0, 1'b0, 0, 1'b1, 1000};
    vecs[2] = '{32'h0000_0040, 1, 1'b0, 0, 1'b0, 17};
    vecs[3] = '{32'h0000_0F9C, 0, 1'b0, 0, 1'b0, 1000};
    vecs[4] = '{32'h0000_0020, 1, 1'b1, 0, 1'b0, 9};
    vecs[5] = '{32'h0000_0080, 0, 1'b0, 10, 1'b0, 33};
    vecs[6] = '{32'h0000_0080, 0, 1'b0, 0, 1'b0, 33};
    for (int k = 0; k < NREGS; k++) rf[k] = '0;

    #1;
    chk("rst_hold", cpu_hold, 0);
    chk("rst_valid", dump_valid, 0);
    chk("rst_last", dump_last, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sel", reg_sel, 0);
    chk("rst_data", dump_data, 0);
    chk("rst_count", cycle_count, 0);
    step();
    rst = 1'b0;
    step();

    // Disarm mid-RUN: back to IDLE with the count held and no record.
    halt_pc = 32'hFFFF_0000;
    pc = 32'h0;
    arm = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    arm = 1'b0;
    step();
    chk("disarm_run_count", cycle_count, 5);
    for (int i = 0; i < 4; i++) begin
      chk("disarm_run_valid", dump_valid, 0);
      chk("disarm_run_hold", cpu_hold, 0);
      step();
    end

    for (int v = 0; v < 7; v++) run_vec(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
